// File: rtl/btb_assoc_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
// Tree-PLRU helpers work on a 7-bit node vector (enough for 8 ways); node i lives in bit i-1.
package btb_assoc_pkg;

  localparam int TAG_MAX_W  = 29;
  localparam int CTR_MAX_W  = 3;
  localparam int PLRU_MAX_W = 7;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } flush_state_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [29:0]          target;
    logic [CTR_MAX_W-1:0] ctr;
  } btb_entry_t;

  function automatic logic [CTR_MAX_W-1:0] weak_taken(input int ctr_w);
    return CTR_MAX_W'(1 << (ctr_w - 1));
  endfunction

  function automatic int plru_levels(input int ways);
    return (ways >= 8) ? 3 : (ways >= 4) ? 2 : (ways >= 2) ? 1 : 0;
  endfunction

  // A node bit of 1 means the victim lies in the right subtree.
  function automatic logic [2:0] plru_victim(input logic [PLRU_MAX_W-1:0] bits, input int ways);
    int                    node;
    logic [2:0]            way;
    logic [PLRU_MAX_W-1:0] sh;
    node = 1;
    way  = '0;
    for (int lvl = 0; lvl < 3; lvl++) begin
      if (lvl < plru_levels(ways)) begin
        sh   = bits >> (node - 1);
        way  = {way[1:0], sh[0]};
        node = 2 * node + int'(sh[0]);
      end
    end
    return way;
  endfunction

  // Point every node on the path to 'way' away from it.
  function automatic logic [PLRU_MAX_W-1:0] plru_touch(input logic [PLRU_MAX_W-1:0] bits,
                                                       input logic [2:0] way, input int ways);
    int                    node;
    int                    lvls;
    logic [2:0]            sh_way;
    logic [PLRU_MAX_W-1:0] r;
    r    = bits;
    node = 1;
    lvls = plru_levels(ways);
    for (int lvl = 0; lvl < 3; lvl++) begin
      if (lvl < lvls) begin
        sh_way = way >> (lvls - 1 - lvl);
        r      = r & ~(PLRU_MAX_W'(1) << (node - 1));
        if (!sh_way[0]) r = r | (PLRU_MAX_W'(1) << (node - 1));
        node = 2 * node + int'(sh_way[0]);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/btb_plru.sv
// Per-set tree pseudo-LRU state: a lookup touch port, an update touch port and a sweep clear.
// The update touch is applied after the lookup touch when both hit the same set.
module btb_plru
  import btb_assoc_pkg::*;
#(
  parameter int SETS = 8,
  parameter int WAYS = 2,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_set,
  input  logic             rd_touch,
  input  logic [WAY_W-1:0] rd_way,
  input  logic [IDX_W-1:0] up_set,
  input  logic             up_touch,
  input  logic [WAY_W-1:0] up_way,
  input  logic             clr,
  input  logic [IDX_W-1:0] clr_set,
  output logic [WAY_W-1:0] victim
);

  if (WAYS == 1) begin : g_direct
    logic unused_in;
    assign unused_in = ^{clk, rst_n, rd_set, rd_touch, rd_way, up_set, up_touch, up_way, clr, clr_set};
    assign victim    = '0;
  end else begin : g_tree
    logic [WAYS-2:0]       plru_q [SETS];
    logic [PLRU_MAX_W-1:0] rd_next;
    logic [PLRU_MAX_W-1:0] up_base;
    logic [PLRU_MAX_W-1:0] up_next;

    always_comb begin
      rd_next = plru_touch(PLRU_MAX_W'(plru_q[rd_set]), 3'(rd_way), WAYS);
      up_base = (rd_touch && rd_set == up_set) ? rd_next : PLRU_MAX_W'(plru_q[up_set]);
      up_next = plru_touch(up_base, 3'(up_way), WAYS);
    end

    assign victim = WAY_W'(plru_victim(PLRU_MAX_W'(plru_q[up_set]), WAYS));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
      end else if (clr) begin
        plru_q[clr_set] <= '0;
      end else begin
        if (rd_touch) plru_q[rd_set] <= rd_next[WAYS-2:0];
        if (up_touch) plru_q[up_set] <= up_next[WAYS-2:0];
      end
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// N-way set-associative BTB: combinational IF lookup, EX update/allocate, sequenced flush sweep.
// Define BTB_ASSOC_STATS_EN to add saturating lookup/hit/update/mispredict counters.
module btb_assoc
  import btb_assoc_pkg::*;
#(
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int CTR_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic        valid,
  output logic [31:0] target,
  output logic        predicted_taken,
  input  logic        update,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken,
  input  logic        mispredicted,
  input  logic        flush,
  output logic        flush_busy
`ifdef BTB_ASSOC_STATS_EN
  ,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_MAX_W-1:0] CTR_MAX = CTR_MAX_W'((1 << CTR_W) - 1);

  logic                 valid_q [SETS][WAYS];
  logic [CTR_MAX_W-1:0] ctr_q   [SETS][WAYS];
  logic [TAG_W-1:0]     tag_q   [SETS][WAYS];
  logic [29:0]          tgt_q   [SETS][WAYS];

  flush_state_e     state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  btb_entry_t       lk_e [WAYS];
  btb_entry_t       up_e [WAYS];
  btb_entry_t       hit_e;
  logic [WAYS-1:0]  lk_hit_vec, up_hit_vec;
  logic [WAY_W-1:0] lk_way, up_way, free_way, victim_way, alloc_way;
  logic             idle, lk_hit, up_hit, has_free, up_acc, up_alloc;
  logic [CTR_MAX_W-1:0] uc;
  logic             unused_low;

  assign lk_idx     = pc[IDX_W+1:2];
  assign lk_tag     = pc[31:IDX_W+2];
  assign up_idx     = update_pc[IDX_W+1:2];
  assign up_tag     = update_pc[31:IDX_W+2];
  assign unused_low = ^{pc[1:0], update_pc[1:0], update_target[1:0]};
  assign idle       = (state_q == IDLE);

  // Descending scan so the lowest-numbered matching or free way wins.
  always_comb begin
    lk_way   = '0;
    up_way   = '0;
    free_way = '0;
    has_free = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      lk_e[w] = '{valid: valid_q[lk_idx][w], tag: TAG_MAX_W'(tag_q[lk_idx][w]),
                  target: tgt_q[lk_idx][w], ctr: ctr_q[lk_idx][w]};
      up_e[w] = '{valid: valid_q[up_idx][w], tag: TAG_MAX_W'(tag_q[up_idx][w]),
                  target: tgt_q[up_idx][w], ctr: ctr_q[up_idx][w]};
      lk_hit_vec[w] = lk_e[w].valid && (lk_e[w].tag == TAG_MAX_W'(lk_tag));
      up_hit_vec[w] = up_e[w].valid && (up_e[w].tag == TAG_MAX_W'(up_tag));
      if (lk_hit_vec[w]) lk_way = WAY_W'(w);
      if (up_hit_vec[w]) up_way = WAY_W'(w);
      if (!up_e[w].valid) begin
        free_way = WAY_W'(w);
        has_free = 1'b1;
      end
    end
  end

  assign lk_hit          = idle && (|lk_hit_vec);
  assign hit_e           = lk_e[lk_way];
  assign valid           = lk_hit;
  assign target          = lk_hit ? {hit_e.target, 2'b00} : 32'd0;
  assign predicted_taken = lk_hit && hit_e.ctr[CTR_W-1];
  assign flush_busy      = (state_q == SWEEP);

  assign up_hit    = |up_hit_vec;
  assign up_acc    = update && idle && !flush;
  assign up_alloc  = up_acc && !up_hit && update_taken;
  assign alloc_way = has_free ? free_way : victim_way;
  assign uc        = up_e[up_way].ctr;

  btb_plru #(.SETS(SETS), .WAYS(WAYS)) u_plru (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_set   (lk_idx),
    .rd_touch (lk_hit),
    .rd_way   (lk_way),
    .up_set   (up_idx),
    .up_touch (up_acc && (up_hit || update_taken)),
    .up_way   (up_hit ? up_way : alloc_way),
    .clr      (state_q == SWEEP),
    .clr_set  (sweep_q),
    .victim   (victim_way)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          ctr_q[s][w]   <= '0;
        end
      end
    end else begin
      if (state_q == SWEEP) begin
        for (int w = 0; w < WAYS; w++) valid_q[sweep_q][w] <= 1'b0;
      end
      if (up_acc && up_hit) begin
        if (update_taken)      ctr_q[up_idx][up_way] <= (uc == CTR_MAX) ? uc : uc + CTR_MAX_W'(1);
        else if (mispredicted) ctr_q[up_idx][up_way] <= '0;
        else                   ctr_q[up_idx][up_way] <= (uc == '0) ? uc : uc - CTR_MAX_W'(1);
      end else if (up_alloc) begin
        valid_q[up_idx][alloc_way] <= 1'b1;
        ctr_q[up_idx][alloc_way]   <= weak_taken(CTR_W);
      end
    end
  end

  // Tag and target payload carry no reset; the valid bit qualifies them.
  always_ff @(posedge clk) begin
    if (up_acc && up_hit && update_taken) begin
      tgt_q[up_idx][up_way] <= update_target[31:2];
    end else if (up_alloc) begin
      tag_q[up_idx][alloc_way] <= up_tag;
      tgt_q[up_idx][alloc_way] <= update_target[31:2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = SWEEP;
          sweep_d = '0;
        end
      end
      SWEEP: begin
        if (flush)                              sweep_d = '0;
        else if (sweep_q == IDX_W'(SETS - 1))   state_d = IDLE;
        else                                    sweep_d = sweep_q + IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BTB_ASSOC_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (flush) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else begin
      stat_lookups     <= sat_inc(stat_lookups, idle);
      stat_hits        <= sat_inc(stat_hits, lk_hit);
      stat_updates     <= sat_inc(stat_updates, up_acc);
      stat_mispredicts <= sat_inc(stat_mispredicts, update && mispredicted);
    end
  end
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc (SETS=8, WAYS=2, CTR_W=2): directed scenarios plus random traffic
// against a reference model using true-LRU timestamps and whole-table flush semantics.
module tb_btb_assoc;

  localparam int SETS     = 8;
  localparam int WAYS     = 2;
  localparam int CTR_W    = 2;
  localparam int CTR_MAX  = (1 << CTR_W) - 1;
  localparam int WEAK     = 1 << (CTR_W - 1);
  localparam logic [31:0] IDLE_PC = 32'h0000_00F0;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] pc = IDLE_PC, update_pc = '0, update_target = '0;
  logic        update = 1'b0, update_taken = 1'b0, mispredicted = 1'b0, flush = 1'b0;
  logic        valid, predicted_taken, flush_busy;
  logic [31:0] target;
`ifdef BTB_ASSOC_STATS_EN
  logic [31:0] stat_lookups, stat_hits, stat_updates, stat_mispredicts;
`endif

  btb_assoc #(.SETS(SETS), .WAYS(WAYS), .CTR_W(CTR_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc              (pc),
    .valid           (valid),
    .target          (target),
    .predicted_taken (predicted_taken),
    .update          (update),
    .update_pc       (update_pc),
    .update_target   (update_target),
    .update_taken    (update_taken),
    .mispredicted    (mispredicted),
    .flush           (flush),
    .flush_busy      (flush_busy)
`ifdef BTB_ASSOC_STATS_EN
    ,
    .stat_lookups     (stat_lookups),
    .stat_hits        (stat_hits),
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  bit          m_valid [SETS][WAYS];
  int          m_tag   [SETS][WAYS];
  logic [31:0] m_tgt   [SETS][WAYS];
  int          m_ctr   [SETS][WAYS];
  longint      m_stamp [SETS][WAYS];
  longint      m_time;
  int          m_busy;

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 2) % SETS);
  endfunction

  function automatic int tag_of(input logic [31:0] a);
    return int'(a >> (2 + $clog2(SETS)));
  endfunction

  function automatic int m_find(input logic [31:0] a);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[set_of(a)][w] && m_tag[set_of(a)][w] == tag_of(a)) return w;
    return -1;
  endfunction

  function automatic int m_victim(input int s);
    int v;
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
    v = 0;
    for (int w = 1; w < WAYS; w++) if (m_stamp[s][w] < m_stamp[s][v]) v = w;
    return v;
  endfunction

  task automatic m_touch(input int s, input int w);
    m_time++;
    m_stamp[s][w] = m_time;
  endtask

  task automatic m_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_ctr[s][w]   = 0;
        m_stamp[s][w] = 0;
      end
    m_busy = 0;
  endtask

  task automatic check_outputs();
    int          w;
    logic        e_valid, e_pt;
    logic [31:0] e_tgt;
    w       = m_find(pc);
    e_valid = (m_busy == 0) && (w >= 0);
    e_tgt   = e_valid ? m_tgt[set_of(pc)][w] : 32'd0;
    e_pt    = e_valid && (m_ctr[set_of(pc)][w] >= WEAK);
    check("valid", {31'd0, valid}, {31'd0, e_valid});
    check("target", target, e_tgt);
    check("pred_taken", {31'd0, predicted_taken}, {31'd0, e_pt});
    check("flush_busy", {31'd0, flush_busy}, {31'd0, m_busy > 0});
  endtask

  task automatic m_step();
    int ls, lw, us, uw, vw;
    if (m_busy > 0) begin
      m_busy = flush ? SETS : m_busy - 1;
      return;
    end
    if (flush) begin
      for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
      m_busy = SETS;
      return;
    end
    ls = set_of(pc);
    lw = m_find(pc);
    us = set_of(update_pc);
    uw = m_find(update_pc);
    vw = m_victim(us);
    if (lw >= 0) m_touch(ls, lw);
    if (update) begin
      if (uw >= 0) begin
        if (update_taken) begin
          if (m_ctr[us][uw] < CTR_MAX) m_ctr[us][uw]++;
          m_tgt[us][uw] = update_target & 32'hFFFF_FFFC;
        end else if (mispredicted) begin
          m_ctr[us][uw] = 0;
        end else if (m_ctr[us][uw] > 0) begin
          m_ctr[us][uw]--;
        end
        m_touch(us, uw);
      end else if (update_taken) begin
        m_valid[us][vw] = 1;
        m_tag[us][vw]   = tag_of(update_pc);
        m_tgt[us][vw]   = update_target & 32'hFFFF_FFFC;
        m_ctr[us][vw]   = WEAK;
        m_touch(us, vw);
      end
    end
  endtask

  // driver tasks
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    pc = IDLE_PC; update = 0; flush = 0; mispredicted = 0; update_taken = 0;
  endtask

  task automatic apply_reset();
    set_idle();
    rst_n = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic do_update(input logic [31:0] a, input logic [31:0] t, input logic tk, input logic mp);
    update = 1; update_pc = a; update_target = t; update_taken = tk; mispredicted = mp;
    cycle();
    update = 0; mispredicted = 0;
  endtask

  task automatic expect_lookup(input string tag, input logic [31:0] a, input logic ev,
                               input logic [31:0] et, input logic ep);
    pc = a;
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, valid}, {31'd0, ev});
    check({tag, "_target"}, target, et);
    check({tag, "_pt"}, {31'd0, predicted_taken}, {31'd0, ep});
    check_outputs();
    m_step();
    @(posedge clk);
    #1 pc = IDLE_PC;
  endtask

  function automatic logic [31:0] rand_addr();
    return (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, SETS - 1)) << 2)
         | 32'($urandom_range(0, 3));
  endfunction

  task automatic flush_and_count(output int busy_cycles);
    flush = 1;
    cycle();
    flush = 0;
    busy_cycles = 0;
    for (int i = 0; i < 20 && flush_busy; i++) begin
      busy_cycles++;
      update = 1; update_pc = rand_addr(); update_target = $urandom; update_taken = 1;
      cycle();
    end
    set_idle();
  endtask

  int busy_n;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();

    // reset state
    expect_lookup("reset", 32'h100, 0, 32'h0, 0);
    check("reset_busy", {31'd0, flush_busy}, 32'd0);

    // allocate and hit
    do_update(32'h100, 32'h200, 1, 0);
    expect_lookup("alloc", 32'h100, 1, 32'h200, 1);

    // counter walks down; the mispredict forces strong not-taken
    do_update(32'h100, 32'h444, 0, 0);
    expect_lookup("dec1", 32'h100, 1, 32'h200, 0);
    do_update(32'h100, 32'h444, 0, 0);
    do_update(32'h100, 32'h444, 0, 1);
    expect_lookup("dec3", 32'h100, 1, 32'h200, 0);

    // strong taken then mispredict: must drop to 0, so one taken leaves it weakly not-taken
    do_update(32'h144, 32'h800, 1, 0);
    do_update(32'h144, 32'h800, 1, 0);
    expect_lookup("sat", 32'h144, 1, 32'h800, 1);
    do_update(32'h144, 32'h800, 0, 1);
    do_update(32'h144, 32'h804, 1, 0);
    expect_lookup("forced", 32'h144, 1, 32'h804, 0);

    // PLRU eviction in set 0
    apply_reset();
    do_update(32'h100, 32'h1000, 1, 0);
    do_update(32'h200, 32'h2000, 1, 0);
    expect_lookup("lru_touch", 32'h100, 1, 32'h1000, 1);
    do_update(32'h300, 32'h3000, 1, 0);
    expect_lookup("lru_keep", 32'h100, 1, 32'h1000, 1);
    expect_lookup("lru_evict", 32'h200, 0, 32'h0, 0);
    expect_lookup("lru_new", 32'h300, 1, 32'h3000, 1);

    // flush sweep
    for (int i = 0; i < 12; i++) do_update(rand_addr(), $urandom, 1, 0);
    do_update(32'h104, 32'h5000, 1, 0);
    flush_and_count(busy_n);
    check("busy_cycles", 32'(busy_n), 32'd8);
    expect_lookup("post_flush_a", 32'h104, 0, 32'h0, 0);
    expect_lookup("post_flush_b", 32'h300, 0, 32'h0, 0);

    // flush while sweeping restarts the count
    flush = 1; cycle(); flush = 0;
    repeat (3) cycle();
    flush = 1; cycle(); flush = 0;
    busy_n = 0;
    for (int i = 0; i < 20 && flush_busy; i++) begin busy_n++; cycle(); end
    check("restart_cycles", 32'(busy_n), 32'd8);

    // reset during the 4th sweep cycle
    do_update(32'h104, 32'h5000, 1, 0);
    flush = 1; cycle(); flush = 0;
    repeat (3) cycle();
    pc = 32'h104;
    #2 rst_n = 0;
    m_reset();
    #1;
    check("async_busy", {31'd0, flush_busy}, 32'd0);
    check("async_valid", {31'd0, valid}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1;
    set_idle();
    expect_lookup("rst_miss", 32'h104, 0, 32'h0, 0);
    do_update(32'h104, 32'h6000, 1, 0);
    expect_lookup("rst_alloc", 32'h104, 1, 32'h6000, 1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      pc            = rand_addr();
      update        = ($urandom_range(0, 99) < 60);
      update_pc     = rand_addr();
      update_target = $urandom;
      update_taken  = ($urandom_range(0, 99) < 60);
      mispredicted  = ($urandom_range(0, 99) < 20);
      flush         = ($urandom_range(0, 99) < 2);
      cycle();
    end
    set_idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
